// File: rtl/vend_fsm_param.sv
// Parametrised vending FSM: accumulates quarter-unit credit, vends at PRICE_Q, returns paced change.
// Define VEND_REFUND_EN to add the cancel input, which refunds collected credit as change.
module vend_fsm_param #(
  parameter int unsigned PRICE_Q   = 5,
  parameter int unsigned PULSE_GAP = 0,
  localparam int unsigned CW       = $clog2(PRICE_Q + 4) + 1
) (
  input  logic          CLK,
  input  logic          RES,
  input  logic          quarter,
  input  logic          halfDollar,
  input  logic          dollar,
`ifdef VEND_REFUND_EN
  input  logic          cancel,
`endif
  output logic          guffin,
  output logic          ret_half,
  output logic          ret_quarter,
  output logic          coin_reject,
  output logic [1:0]    state,
  output logic [CW-1:0] credit,
  output logic [CW-1:0] change
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StVend    = 2'd2,
    StChange  = 2'd3
  } state_e;

  localparam logic [CW-1:0] Price   = CW'(PRICE_Q);
  localparam logic [7:0]    GapInit = 8'(PULSE_GAP);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] change_q, change_d;
  logic [CW-1:0] coin_val, new_credit;
  logic [7:0]    gap_q, gap_d;
  logic          reject_q, reject_d;
  logic          any_coin, valid_coin, do_cancel;

  always_comb begin
    any_coin   = quarter | halfDollar | dollar;
    valid_coin = $onehot({quarter, halfDollar, dollar});
    coin_val   = dollar ? CW'(4) : (halfDollar ? CW'(2) : CW'(1));
    new_credit = credit_q + coin_val;
`ifdef VEND_REFUND_EN
    do_cancel  = cancel & (state_q == StCollect);
`else
    do_cancel  = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    credit_d    = credit_q;
    change_d    = change_q;
    gap_d       = gap_q;
    reject_d    = any_coin & ~valid_coin;
    guffin      = 1'b0;
    ret_half    = 1'b0;
    ret_quarter = 1'b0;
    unique case (state_q)
      StIdle, StCollect: begin
        if (do_cancel) begin
          // Refund wins over a simultaneous coin, which is then bounced.
          change_d = credit_q;
          credit_d = '0;
          gap_d    = '0;
          state_d  = StChange;
          reject_d = any_coin;
        end else if (valid_coin) begin
          credit_d = new_credit;
          state_d  = (new_credit >= Price) ? StVend : StCollect;
        end
      end
      StVend: begin
        guffin   = 1'b1;
        change_d = credit_q - Price;
        credit_d = '0;
        gap_d    = '0;
        state_d  = (credit_q > Price) ? StChange : StIdle;
        reject_d = any_coin;
      end
      StChange: begin
        reject_d = any_coin;
        if (gap_q != '0) begin
          gap_d = gap_q - 8'd1;
        end else begin
          ret_half    = (change_q >= CW'(2));
          ret_quarter = (change_q == CW'(1));
          change_d    = change_q - (ret_half ? CW'(2) : CW'(1));
          if (change_d == '0) begin
            state_d = StIdle;
            gap_d   = '0;
          end else begin
            gap_d = GapInit;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      state_q  <= StIdle;
      credit_q <= '0;
      change_q <= '0;
      gap_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      change_q <= change_d;
      gap_q    <= gap_d;
      reject_q <= reject_d;
    end
  end

  assign state       = state_q;
  assign credit      = credit_q;
  assign change      = change_q;
  assign coin_reject = reject_q;

endmodule
